// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetches 32-bit instruction words from a synchronous instruction memory
// (1-cycle read latency) and hands them to decode through a valid/ready
// handshake. Owns the PC and applies redirects from EX. A 2-entry FIFO plus
// one in-flight read slot sustains one instruction per cycle.
//
// Ports
//   clk_i            clock, all state on the rising edge
//   arst_i           asynchronous active-high reset
//   en_i             fetch enable (0 = no new requests, in-flight completes)
//   imem_req_o       read request to instruction memory
//   imem_addr_o      read byte address (= PC, bits[1:0] always 0)
//   imem_rdata_i     read data, valid one cycle after an issued request
//   instr_valid_o    FIFO head holds a valid instruction
//   instr_ready_i    decode accepts the head this cycle
//   instr_o          head instruction word
//   instr_pc_o       PC of the head instruction
//   opcode_o         instr_o[6:0], for the control unit
//   redirect_i       flush and restart fetch at redirect_pc_i
//   redirect_pc_i    new PC, bits[1:0] forced to 0
//   instr_illegal_o  head opcode not supported (only with the macro below)
//
// Build option
//   ILLEGAL_OPCODE_CHECK_EN : when defined, each FIFO entry stores an
//   "illegal opcode" flag computed at push time and instr_illegal_o reports
//   it for the head entry. When undefined, instr_illegal_o is tied to 0 and
//   no flag storage exists.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               en_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic [6:0]         opcode_o,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               instr_illegal_o
);

  // Architectural state
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [1:0]         count_q, count_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

  // FIFO storage (2 entries)
  logic [INSTR_W-1:0] fifo_instr_q [2];
  logic [ADDR_W-1:0]  fifo_pc_q    [2];

  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         credit_used;

  // Occupancy the FIFO will need once the current in-flight word lands,
  // counting the slot freed by a pop this cycle. Issuing only while this is
  // below 2 guarantees every returning word has a free entry.
  assign credit_used = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};

  always_comb begin
    pop           = instr_valid_o & instr_ready_i;
    push          = inflight_q & ~redirect_i;
    issue         = ~arst_i & en_i & ~redirect_i & (credit_used < 3'd2);

    pc_d          = pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;

    if (redirect_i) begin
      // Flush wins over pop/push/issue; the in-flight response is dropped
      // simply by not pushing it (inflight_d stays 0).
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = redirect_pc_i & ~ADDR_W'(3);
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pc_q          <= RESET_PC;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // FIFO data: reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign imem_req_o    = issue;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (count_q != 2'd0);
  assign instr_o       = fifo_instr_q[rd_ptr_q];
  assign instr_pc_o    = fifo_pc_q[rd_ptr_q];
  assign opcode_o      = instr_o[6:0];

`ifdef ILLEGAL_OPCODE_CHECK_EN
  logic fifo_ill_q [2];
  logic push_illegal;

  always_comb begin
    case (imem_rdata_i[6:0])
      7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b0000011, 7'b0100011: push_illegal = 1'b0;
      default:                            push_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < 2; i++) begin
        fifo_ill_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_ill_q[wr_ptr_q] <= push_illegal;
    end
  end

  assign instr_illegal_o = instr_valid_o & fifo_ill_q[rd_ptr_q];
`else
  assign instr_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus, a queue-based reference
// model of the fetch unit and a small instruction-memory model. A second
// instance with RESET_PC = 2^64-4 shows PC wrap-around.
module tb_instr_fetch_unit;

  localparam logic [63:0] RPC  = 64'h100;
  localparam logic [63:0] WRPC = 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef ILLEGAL_OPCODE_CHECK_EN
  localparam bit ILL_ON = 1'b1;
`else
  localparam bit ILL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst;
  logic        en, ready, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] rdata;
  logic        imem_req, instr_valid, instr_illegal;
  logic [63:0] imem_addr, instr_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;

  // wrap-test instance signals
  logic        w_en = 1'b1, w_ready = 1'b1, w_redirect = 1'b0;
  logic [63:0] w_rpc = 64'h0;
  logic [31:0] w_rdata = 32'h0;
  logic        w_req, w_valid, w_ill;
  logic [63:0] w_addr, w_ipc;
  logic [31:0] w_instr;
  logic [6:0]  w_op;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(RPC)) dut (
    .clk_i(clk), .arst_i(arst), .en_i(en),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(rdata),
    .instr_valid_o(instr_valid), .instr_ready_i(ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .opcode_o(opcode),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_illegal_o(instr_illegal)
  );

  instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(WRPC)) u_wrap (
    .clk_i(clk), .arst_i(arst), .en_i(w_en),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
    .instr_valid_o(w_valid), .instr_ready_i(w_ready),
    .instr_o(w_instr), .instr_pc_o(w_ipc), .opcode_o(w_op),
    .redirect_i(w_redirect), .redirect_pc_i(w_rpc),
    .instr_illegal_o(w_ill)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Instruction memory contents: two fixed words for the opcode test, a
  // varied address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h300) return 32'h0000_0073;
    if (a == 64'h304) return 32'h0000_0033;
    return {a[25:2], 1'b0, a[8:2] ^ 7'h13};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100011 ||
           op == 7'b1101111 || op == 7'b0000011 || op == 7'b0100011;
  endfunction

  // Reference model: queue of delivered-but-unconsumed instructions,
  // the PC, and the outstanding memory read.
  typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_infl;
  logic [63:0] m_infl_pc;

  // Snapshot of outputs at the mid-cycle sample point.
  logic        s_req, s_valid, s_ill, sw_req;
  logic [63:0] s_addr, s_pc, sw_addr;
  logic [31:0] s_instr;
  logic [6:0]  s_op;

  task automatic model_reset();
    mq.delete();
    m_pc   = RPC;
    m_infl = 0;
  endtask

  task automatic model_cycle();
    int  n;
    bit  vm, pop, push, issue;
    ent_t e;
    n     = mq.size();
    vm    = (n > 0);
    pop   = vm && ready;
    push  = m_infl && !redirect;
    issue = en && !redirect && ((n - int'(pop) + int'(m_infl)) < 2);
    chk("valid", s_valid, vm);
    if (vm) begin
      chk("instr", s_instr, mq[0].instr);
      chk("instr_pc", s_pc, mq[0].pc);
      chk("opcode", s_op, mq[0].instr[6:0]);
      chk("illegal", s_ill, ILL_ON && !legal(mq[0].instr[6:0]));
    end else begin
      chk("illegal_idle", s_ill, 1'b0);
    end
    chk("imem_req", s_req, issue);
    if (issue) chk("imem_addr", s_addr, m_pc);
    if (redirect) begin
      mq.delete();
      m_infl = 0;
      m_pc   = redirect_pc & ~64'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.instr = mem_word(m_infl_pc);
        e.pc    = m_infl_pc;
        mq.push_back(e);
      end
      if (issue) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 64'd4;
        m_infl    = 1;
      end else begin
        m_infl = 0;
      end
    end
  endtask

  // One clock cycle: called at posedge+1, drives inputs, samples at the
  // falling edge, checks/updates the model, then returns memory data.
  task automatic step(input logic e, input logic r, input logic rd, input logic [63:0] rpc);
    en = e; ready = r; redirect = rd; redirect_pc = rpc;
    #4;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_pc = instr_pc; s_op = opcode; s_ill = instr_illegal;
    sw_req = w_req; sw_addr = w_addr;
    model_cycle();
    @(posedge clk); #1;
    cyc++;
    rdata = s_req ? mem_word(s_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"}, instr_pc, 64'h0);
    chk({tag, "_ill"}, instr_illegal, 1'b0);
    chk({tag, "_wvalid"}, w_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    int          nreq;

    arst = 1'b1; en = 1'b1; ready = 1'b1; redirect = 1'b0;
    redirect_pc = 64'h0; rdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("rst");
    arst = 1'b0;
    model_reset();

    // T1 + T4: consecutive fetch addresses, 2-cycle latency, wrap
    step(1, 1, 0, 0);
    chk("t1_addr0", s_addr, 64'h100); chk("t1_req0", s_req, 1'b1);
    chk("t1_valid0", s_valid, 1'b0);
    chk("t4_waddr0", sw_addr, WRPC);
    step(1, 1, 0, 0);
    chk("t1_addr1", s_addr, 64'h104); chk("t1_valid1", s_valid, 1'b0);
    chk("t4_waddr1", sw_addr, 64'h0); chk("t4_wreq1", sw_req, 1'b1);
    step(1, 1, 0, 0);
    chk("t1_addr2", s_addr, 64'h108); chk("t1_valid2", s_valid, 1'b1);
    chk("t1_pc2", s_pc, 64'h100);
    chk("t1_instr2", s_instr, mem_word(64'h100));
    step(1, 1, 0, 0);
    chk("t1_pc3", s_pc, 64'h104);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // T2: backpressure, head stable, bounded requests, no loss on release
    nreq = 0;
    step(1, 0, 0, 0);
    hold_pc = s_pc; hold_instr = s_instr; nreq += int'(s_req);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("t2_pc_stable", s_pc, hold_pc);
      chk("t2_instr_stable", s_instr, hold_instr);
      nreq += int'(s_req);
    end
    chk("t2_req_bound", 64'(nreq <= 2), 64'd1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // T3: redirect with a full buffer, then back-to-back redirects
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 64'h2003);
    chk("t3_redir_req", s_req, 1'b0);
    step(1, 1, 0, 0);
    chk("t3_valid", s_valid, 1'b0); chk("t3_addr", s_addr, 64'h2000);
    chk("t3_req", s_req, 1'b1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t3_pc_first", s_pc, 64'h2000);
    step(1, 1, 0, 0);
    step(1, 1, 1, 64'h5000);
    step(1, 1, 1, 64'h6001);
    step(1, 1, 0, 0);
    chk("t3_b2b_addr", s_addr, 64'h6000); chk("t3_b2b_valid", s_valid, 1'b0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // T6: illegal-opcode flag travels with its word
    step(1, 1, 1, 64'h300);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t6_pc300", s_pc, 64'h300); chk("t6_ill73", s_ill, ILL_ON);
    step(1, 1, 0, 0);
    chk("t6_pc304", s_pc, 64'h304); chk("t6_ill33", s_ill, 1'b0);

    // en=0 drain and a mixed pattern of enable/ready/redirect
    for (int i = 0; i < 5; i++) step(0, (i % 2) == 0, 0, 0);
    chk("en0_no_req", s_req, 1'b0);
    for (int i = 0; i < 40; i++)
      step((i % 7) != 5, (i % 3) != 0, (i % 13) == 9, 64'h1000 + 64'(i * 64));

    // T5: asynchronous reset away from the clock edge
    #2;
    arst = 1'b1;
    #1;
    check_reset_outputs("t5");
    @(posedge clk); #1;
    arst = 1'b0;
    rdata = 32'hDEAD_BEEF;
    model_reset();
    step(1, 1, 0, 0);
    chk("t5_restart_addr", s_addr, 64'h100); chk("t5_wrap0", sw_addr, WRPC);
    step(1, 1, 0, 0);
    chk("t5_wrap1", sw_addr, 64'h0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("t5_pc_after", s_pc, 64'h10C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
